// File: rtl/copy_check.sv
// copy_check: post-copy verifier. Walks source and destination memories in lockstep
// from the given start addresses and compares them word by word. It stops on the
// source sentinel, on the last source address, or on the last destination address.
// It reports the word count, the mismatch count, the first failing destination
// address and the OR of all failing bits.
module copy_check #(
    parameter int unsigned       ADDR_W   = 12,
    parameter int unsigned       WIDTH    = 16,
    parameter logic [WIDTH-1:0]  SENTINEL = {WIDTH{1'b1}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_start,
    input  logic [ADDR_W-1:0] dst_start,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [WIDTH-1:0]  src_rdata,
    output logic [ADDR_W-1:0] dst_addr,
    input  logic [WIDTH-1:0]  dst_rdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_checked,
    output logic [ADDR_W:0]   mismatch_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [WIDTH-1:0]  err_bits,
    output logic              src_end,
    output logic              dst_end
);

    typedef enum logic [1:0] {StIdle, StRd, StCmp, StDone} state_e;

    localparam logic [ADDR_W-1:0] LastAddr = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] PtrOne   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CntOne   = {{ADDR_W{1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
    logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic [ADDR_W:0]   mism_q, mism_d;
    logic [ADDR_W-1:0] first_err_q, first_err_d;
    logic [WIDTH-1:0]  err_bits_q, err_bits_d;
    logic              src_end_q, src_end_d;
    logic              dst_end_q, dst_end_d;

    logic              is_sentinel;
    logic              is_mismatch;
    logic              at_src_last;
    logic              at_dst_last;

    assign is_sentinel = (src_rdata == SENTINEL);
    assign is_mismatch = (src_rdata != dst_rdata);
    assign at_src_last = (src_ptr_q == LastAddr);
    assign at_dst_last = (dst_ptr_q == LastAddr);

    // State and result registers; everything clears asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            src_ptr_q   <= '0;
            dst_ptr_q   <= '0;
            words_q     <= '0;
            mism_q      <= '0;
            first_err_q <= '0;
            err_bits_q  <= '0;
            src_end_q   <= 1'b0;
            dst_end_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_ptr_q   <= src_ptr_d;
            dst_ptr_q   <= dst_ptr_d;
            words_q     <= words_d;
            mism_q      <= mism_d;
            first_err_q <= first_err_d;
            err_bits_q  <= err_bits_d;
            src_end_q   <= src_end_d;
            dst_end_q   <= dst_end_d;
        end
    end

    // Next-state: accept start when idle/done, then alternate RD/CMP until a stop rule fires.
    always_comb begin
        state_d     = state_q;
        src_ptr_d   = src_ptr_q;
        dst_ptr_d   = dst_ptr_q;
        words_d     = words_q;
        mism_d      = mism_q;
        first_err_d = first_err_q;
        err_bits_d  = err_bits_q;
        src_end_d   = src_end_q;
        dst_end_d   = dst_end_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    src_ptr_d   = src_start;
                    dst_ptr_d   = dst_start;
                    words_d     = '0;
                    mism_d      = '0;
                    first_err_d = '0;
                    err_bits_d  = '0;
                    src_end_d   = 1'b0;
                    dst_end_d   = 1'b0;
                    state_d     = StRd;
                end
            end
            StRd: begin
                // Address was presented last cycle; data lands for the CMP cycle.
                state_d = StCmp;
            end
            StCmp: begin
                if (is_sentinel) begin
                    // The sentinel word terminates the block and is never compared.
                    state_d = StDone;
                end else begin
                    words_d = words_q + CntOne;
                    if (is_mismatch) begin
                        mism_d     = mism_q + CntOne;
                        err_bits_d = err_bits_q | (src_rdata ^ dst_rdata);
                        if (mism_q == '0) begin
                            first_err_d = dst_ptr_q;
                        end
                    end
                    if (at_src_last) begin
                        src_end_d = 1'b1;
                    end
                    if (at_dst_last) begin
                        dst_end_d = 1'b1;
                    end
                    if (at_src_last || at_dst_last) begin
                        // Stopping here keeps the pointers from ever wrapping.
                        state_d = StDone;
                    end else begin
                        src_ptr_d = src_ptr_q + PtrOne;
                        dst_ptr_d = dst_ptr_q + PtrOne;
                        state_d   = StRd;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decode straight from registers so reset clears them without a clock.
    always_comb begin
        busy           = (state_q == StRd) || (state_q == StCmp);
        done           = (state_q == StDone);
        src_addr       = src_ptr_q;
        dst_addr       = dst_ptr_q;
        words_checked  = words_q;
        mismatch_cnt   = mism_q;
        first_err_addr = first_err_q;
        err_bits       = err_bits_q;
        src_end        = src_end_q;
        dst_end        = dst_end_q;
    end

endmodule

// File: doc/copy_check.md
# copy_check

Post-copy verifier that sits directly downstream of `top_copy`. After a copy completes, it walks the source and destination memories in lockstep from the same start addresses and compares them word by word. It stops on the same termination rules as the copier: sentinel word, last source address, or last destination address. It reports the words checked, the mismatch count, the first failing destination address and the accumulated failing bits, so soft-error injection on the copy path (e.g. D15) is detectable in hardware.

## Interface

- `ADDR_W`, 12: address width of both memories; last address is `2**ADDR_W-1`.
- `WIDTH`, 16: data word width.
- `SENTINEL`, 16'hFFFF: source end-of-block marker; the sentinel word itself is not compared.

Ports:

- `clk` in 1: single clock, rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request; sampled only in IDLE or DONE.
- `src_start` in ADDR_W: first source address; sampled with `start`.
- `dst_start` in ADDR_W: first destination address; sampled with `start`.
- `src_addr` out ADDR_W: source read address; equals the internal source pointer.
- `src_rdata` in WIDTH: source read data, synchronous read, valid one cycle after `src_addr`.
- `dst_addr` out ADDR_W: destination read address; equals the internal destination pointer.
- `dst_rdata` in WIDTH: destination read data, same 1-cycle latency.
- `busy` out 1: high in RD or CMP.
- `done` out 1: high in DONE; holds until the next accepted `start` or reset.
- `words_checked` out ADDR_W+1: number of compared words.
- `mismatch_cnt` out ADDR_W+1: number of compared words with `src_rdata != dst_rdata`.
- `first_err_addr` out ADDR_W: destination address of the first mismatch; 0 if there is none.
- `err_bits` out WIDTH: OR of `src_rdata ^ dst_rdata` over all compared words.
- `src_end` out 1: termination because the source pointer reached the last address.
- `dst_end` out 1: termination because the destination pointer reached the last address.

## Operation

- States: IDLE, RD, CMP, DONE.
- Reset (async, `rst_n`=0):
  - State goes to IDLE.
  - Pointers, counters, `first_err_addr`, `err_bits`, `src_end`, `dst_end`, `busy` and `done` all go to 0.
- IDLE/DONE with `start`=1:
  - Load pointers from `src_start`/`dst_start`.
  - Clear all counters and result flags.
  - Go to RD.
- `start` is ignored in RD/CMP.
- RD: address already presented; unconditionally go to CMP.
- CMP (read data valid):
  - If `src_rdata == SENTINEL`, go to DONE with no compare and no count change. This check comes first.
  - Otherwise, compare and increment `words_checked`. On mismatch, increment `mismatch_cnt` and OR the XOR into `err_bits`. If this is the first mismatch, capture `dst_addr` into `first_err_addr`.
  - Then, if `src_addr` is the last address, set `src_end`. If `dst_addr` is the last address, set `dst_end`. Both may set in the same cycle. If either is set, go to DONE.
  - Otherwise, increment both pointers and go to RD.
- Pointers never wrap, because termination occurs at the last address.
- Counters are ADDR_W+1 bits wide, so 2**ADDR_W words are representable without overflow.

## Timing

- Each word costs 2 cycles (RD, CMP); there is no pipelining.
- Let E0 be the edge that accepts `start`.
  - Word i is compared at edge E(2i+2).
  - A sentinel at index k produces `done`=1 after edge E(2k+2).
  - `busy` is high from after E0 until that edge.
- `done` and `busy` are never high together.
- A new `start` while in DONE restarts immediately: results clear at that edge and `done` falls.
- Reset asserted mid-check: all outputs go to 0 immediately and asynchronously, not on the next clock edge.
- After `rst_n` rises, the block waits in IDLE for `start`.

## Test plan

- Normal sentinel case:
  - Stimulus: src[0..3] = 1234, ABCD, 0ACE, FFFF; dst[100..102] equal; `src_start`=0, `dst_start`=100.
  - Required: `done` after E8; `words_checked`=3; `mismatch_cnt`=0; `err_bits`=0; `src_end`=`dst_end`=0.
- D15 error:
  - Stimulus: src[10]=55AA, src[11]=FFFF; dst[200]=D5AA.
  - Required: `words_checked`=1; `mismatch_cnt`=1; `first_err_addr`=200; `err_bits`=8000.
- Destination end:
  - Stimulus: `src_start`=20 with 1111, 2222, FFFF; `dst_start`=4094; dst matching.
  - Required: `words_checked`=2; `dst_end`=1; `done` after E4.
- Source end, no sentinel:
  - Stimulus: src[4093..4095] = A001..A003; `dst_start`=300; dst[301] mismatched.
  - Required: `words_checked`=3; `src_end`=1; `mismatch_cnt`=1; `first_err_addr`=301.
- Start while busy:
  - Stimulus: pulse `start` during CMP.
  - Required: pulse ignored; results identical to the normal sentinel case.
- Reset mid-check:
  - Stimulus: drop `rst_n` during CMP of word 1.
  - Required: all outputs 0 immediately; after release and a fresh `start`, the full run completes correctly.
